// File: rtl/vend_ctrl_if.sv
// rtl/vend_ctrl_if.sv - coin/select inputs and display/lamp outputs of the vending controller
interface vend_ctrl_if #(
    parameter int CREDIT_W = 7
);
    logic                coin_u;
    logic                coin_d;
    logic                coin_c;
    logic                cancel;
    logic                sel;
    logic                fseg;
    logic [3:0]          m0;
    logic [3:0]          m1;
    logic [CREDIT_W-1:0] h;
    logic                b1;
    logic                b0;
    logic                ref_lamp;
    logic                coin_rej;
    logic                busy;

    modport master (
        output coin_u, coin_d, coin_c, cancel, sel, fseg,
        input  m0, m1, h, b1, b0, ref_lamp, coin_rej, busy
    );

    modport slave (
        input  coin_u, coin_d, coin_c, cancel, sel, fseg,
        output m0, m1, h, b1, b0, ref_lamp, coin_rej, busy
    );
endinterface

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - parametrised vending controller: binary credit, two products, change, refund
module vend_ctrl #(
    parameter int PRICE_A    = 12,
    parameter int PRICE_B    = 9,
    parameter int COIN_U     = 1,
    parameter int COIN_D     = 2,
    parameter int COIN_C     = 5,
    parameter int MAX_CREDIT = 20,
    parameter int CREDIT_W   = 7,
    parameter int HOLD_TICKS = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    vend_ctrl_if.slave   bus
);

    localparam int SW = CREDIT_W + 1;
    localparam int TW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CREDIT = 3'd1,
        S_VEND   = 3'd2,
        S_REFUND = 3'd3
    } state_t;

    state_t              state;
    logic [CREDIT_W-1:0] credit;
    logic [TW-1:0]       tick_cnt;

    // Coin vectors are ordered {c, d, u}
    logic [2:0] coin_s1, coin_s2, coin_s3;
    logic       cancel_s1, cancel_s2, cancel_s3;
    logic       sel_s1, sel_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coin_s1   <= '0;
            coin_s2   <= '0;
            coin_s3   <= '0;
            cancel_s1 <= 1'b0;
            cancel_s2 <= 1'b0;
            cancel_s3 <= 1'b0;
            sel_s1    <= 1'b0;
            sel_s2    <= 1'b0;
        end else begin
            coin_s1   <= {bus.coin_c, bus.coin_d, bus.coin_u};
            coin_s2   <= coin_s1;
            coin_s3   <= coin_s2;
            cancel_s1 <= bus.cancel;
            cancel_s2 <= cancel_s1;
            cancel_s3 <= cancel_s2;
            sel_s1    <= bus.sel;
            sel_s2    <= sel_s1;
        end
    end

    logic [2:0]          coin_rise;
    logic                cancel_rise;
    logic                coin_any;
    logic                coin_multi;
    logic [SW-1:0]       coin_val;
    logic [SW-1:0]       sum_w;
    logic                fits;
    logic [CREDIT_W-1:0] credit_sum;
    logic [CREDIT_W-1:0] price;
    logic [3:0]          sum_m1;
    logic [3:0]          sum_m0;

    assign coin_rise   = coin_s2 & ~coin_s3;
    assign cancel_rise = cancel_s2 & ~cancel_s3;
    assign coin_any    = |coin_rise;
    assign coin_multi  = (coin_rise[0] & coin_rise[1]) |
                         (coin_rise[0] & coin_rise[2]) |
                         (coin_rise[1] & coin_rise[2]);

    // Highest-priority coin wins; the losers only contribute to coin_rej
    always_comb begin
        coin_val = '0;
        if (coin_rise[0])      coin_val = SW'(COIN_U);
        else if (coin_rise[1]) coin_val = SW'(COIN_D);
        else if (coin_rise[2]) coin_val = SW'(COIN_C);
    end

    assign sum_w      = {1'b0, credit} + coin_val;
    assign fits       = (sum_w <= SW'(MAX_CREDIT));
    assign credit_sum = sum_w[CREDIT_W-1:0];
    assign sum_m1     = 4'(credit_sum / CREDIT_W'(10));
    assign sum_m0     = 4'(credit_sum % CREDIT_W'(10));
    assign price      = sel_s2 ? CREDIT_W'(PRICE_A) : CREDIT_W'(PRICE_B);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            credit       <= '0;
            tick_cnt     <= '0;
            bus.m0       <= 4'd0;
            bus.m1       <= 4'd0;
            bus.h        <= '0;
            bus.b1       <= 1'b0;
            bus.b0       <= 1'b0;
            bus.ref_lamp <= 1'b0;
            bus.coin_rej <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.coin_rej <= coin_multi;
            case (state)
                S_IDLE: begin
                    tick_cnt <= '0;
                    if (coin_any) begin
                        if (fits) begin
                            credit <= credit_sum;
                            bus.m1 <= sum_m1;
                            bus.m0 <= sum_m0;
                            state  <= S_CREDIT;
                        end else begin
                            bus.coin_rej <= 1'b1;
                        end
                    end
                end

                S_CREDIT: begin
                    tick_cnt <= '0;
                    if (cancel_rise) begin
                        bus.coin_rej <= coin_any;
                        bus.h        <= credit;
                        bus.ref_lamp <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= S_REFUND;
                    end else if (credit >= price) begin
                        // Any coin landing on the vend cycle is bounced rather than banked
                        bus.coin_rej <= coin_any;
                        bus.h        <= credit - price;
                        bus.b1       <= sel_s2;
                        bus.b0       <= ~sel_s2;
                        bus.busy     <= 1'b1;
                        state        <= S_VEND;
                    end else if (coin_any) begin
                        if (fits) begin
                            credit <= credit_sum;
                            bus.m1 <= sum_m1;
                            bus.m0 <= sum_m0;
                        end else begin
                            bus.coin_rej <= 1'b1;
                        end
                    end
                end

                S_VEND, S_REFUND: begin
                    bus.coin_rej <= coin_any;
                    if (tick_cnt == TW'(HOLD_TICKS)) begin
                        state        <= S_IDLE;
                        credit       <= '0;
                        tick_cnt     <= '0;
                        bus.m0       <= 4'd0;
                        bus.m1       <= 4'd0;
                        bus.h        <= '0;
                        bus.b1       <= 1'b0;
                        bus.b0       <= 1'b0;
                        bus.ref_lamp <= 1'b0;
                        bus.busy     <= 1'b0;
                    end else if (bus.fseg) begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    credit       <= '0;
                    tick_cnt     <= '0;
                    bus.m0       <= 4'd0;
                    bus.m1       <= 4'd0;
                    bus.h        <= '0;
                    bus.b1       <= 1'b0;
                    bus.b0       <= 1'b0;
                    bus.ref_lamp <= 1'b0;
                    bus.coin_rej <= 1'b0;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - directed bench for vend_ctrl; second instance has PRICE_B=MAX_CREDIT
module tb_vend_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    logic reset2_n;
    logic coin_u, coin_d, coin_c, cancel, sel, fseg;
    int   checks = 0;
    int   errors = 0;

    localparam logic [2:0] CU = 3'b001;
    localparam logic [2:0] CD = 3'b010;
    localparam logic [2:0] CC = 3'b100;

    always #5 clk = ~clk;

    vend_ctrl_if #(.CREDIT_W(7)) bus ();
    vend_ctrl_if #(.CREDIT_W(7)) bus2 ();

    assign bus.coin_u  = coin_u;
    assign bus.coin_d  = coin_d;
    assign bus.coin_c  = coin_c;
    assign bus.cancel  = cancel;
    assign bus.sel     = sel;
    assign bus.fseg    = fseg;
    assign bus2.coin_u = coin_u;
    assign bus2.coin_d = coin_d;
    assign bus2.coin_c = coin_c;
    assign bus2.cancel = cancel;
    assign bus2.sel    = sel;
    assign bus2.fseg   = fseg;

    vend_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    vend_ctrl #(.PRICE_B(20)) dut2 (
        .clk     (clk),
        .reset_n (reset2_n),
        .bus     (bus2)
    );

    // {m1,m0} as two BCD nibbles; flags = {b1, b0, ref_lamp, busy}
    wire [7:0] disp   = {bus.m1, bus.m0};
    wire [3:0] flags  = {bus.b1, bus.b0, bus.ref_lamp, bus.busy};
    wire [7:0] disp2  = {bus2.m1, bus2.m0};
    wire [3:0] flags2 = {bus2.b1, bus2.b0, bus2.ref_lamp, bus2.busy};

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic coin_in(input logic [2:0] m);
        {coin_c, coin_d, coin_u} = m;
        cycles(3);
    endtask

    task automatic coin_out();
        {coin_c, coin_d, coin_u} = 3'b000;
        cycles(3);
    endtask

    task automatic tick_sec();
        fseg = 1'b1;
        cycles(1);
        fseg = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; reset2_n = 1'b0;
        {coin_c, coin_d, coin_u} = 3'b000;
        cancel = 1'b0; sel = 1'b0; fseg = 1'b0;
        cycles(2);
        if (disp !== 8'h00) begin errors++; $display("FAIL reset_disp: got %h expected %h", disp, 8'h00); end
        checks++;
        if (bus.h !== 7'd0) begin errors++; $display("FAIL reset_h: got %0d expected %0d", bus.h, 0); end
        checks++;
        if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected %b", flags, 4'b0000); end
        checks++;
        if (bus.coin_rej !== 1'b0) begin errors++; $display("FAIL reset_rej: got %b expected %b", bus.coin_rej, 1'b0); end
        checks++;
        reset_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_vend_b();
        sel = 1'b0;
        cycles(3);
        coin_in(CC);
        if (disp !== 8'h05) begin errors++; $display("FAIL vend_b_credit5: got %h expected %h", disp, 8'h05); end
        checks++;
        coin_out();
        coin_in(CC);
        if (disp !== 8'h10) begin errors++; $display("FAIL vend_b_credit10: got %h expected %h", disp, 8'h10); end
        checks++;
        coin_out();
        if (flags !== 4'b0101) begin errors++; $display("FAIL vend_b_flags: got %b expected %b", flags, 4'b0101); end
        checks++;
        if (bus.h !== 7'd1) begin errors++; $display("FAIL vend_b_change: got %0d expected %0d", bus.h, 1); end
        checks++;
        if (disp !== 8'h10) begin errors++; $display("FAIL vend_b_frozen: got %h expected %h", disp, 8'h10); end
        checks++;
        tick_sec();
        tick_sec();
        if (flags !== 4'b0101) begin errors++; $display("FAIL vend_b_hold_end: got %b expected %b", flags, 4'b0101); end
        checks++;
        cycles(1);
        if ({flags, bus.h, disp} !== 19'd0) begin
            errors++; $display("FAIL vend_b_idle: got flags=%b h=%0d disp=%h expected all zero", flags, bus.h, disp);
        end
        checks++;
    endtask

    task automatic test_vend_a();
        sel = 1'b1;
        cycles(3);
        coin_in(CC); coin_out();
        coin_in(CC); coin_out();
        if (flags !== 4'b0000) begin errors++; $display("FAIL vend_a_no_vend10: got %b expected %b", flags, 4'b0000); end
        checks++;
        coin_in(CD);
        if (disp !== 8'h12) begin errors++; $display("FAIL vend_a_credit12: got %h expected %h", disp, 8'h12); end
        checks++;
        coin_out();
        if (flags !== 4'b1001) begin errors++; $display("FAIL vend_a_flags: got %b expected %b", flags, 4'b1001); end
        checks++;
        if (bus.h !== 7'd0) begin errors++; $display("FAIL vend_a_change: got %0d expected %0d", bus.h, 0); end
        checks++;
        coin_in(CU);
        if (bus.coin_rej !== 1'b1) begin errors++; $display("FAIL vend_a_busy_rej: got %b expected %b", bus.coin_rej, 1'b1); end
        checks++;
        if (disp !== 8'h12) begin errors++; $display("FAIL vend_a_busy_disp: got %h expected %h", disp, 8'h12); end
        checks++;
        coin_out();
        if (bus.coin_rej !== 1'b0) begin errors++; $display("FAIL vend_a_rej_pulse: got %b expected %b", bus.coin_rej, 1'b0); end
        checks++;
        tick_sec(); tick_sec(); cycles(1);
        if (flags !== 4'b0000) begin errors++; $display("FAIL vend_a_idle: got %b expected %b", flags, 4'b0000); end
        checks++;
    endtask

    task automatic test_refund();
        sel = 1'b0;
        cancel = 1'b1; cycles(3); cancel = 1'b0; cycles(3);
        if ({flags, disp} !== 12'd0) begin errors++; $display("FAIL idle_cancel: got flags=%b disp=%h expected zero", flags, disp); end
        checks++;
        coin_in(CD); coin_out();
        coin_in(CD);
        if (disp !== 8'h04) begin errors++; $display("FAIL refund_credit4: got %h expected %h", disp, 8'h04); end
        checks++;
        coin_out();
        cancel = 1'b1;
        cycles(3);
        if (flags !== 4'b0011) begin errors++; $display("FAIL refund_flags: got %b expected %b", flags, 4'b0011); end
        checks++;
        if (bus.h !== 7'd4) begin errors++; $display("FAIL refund_h: got %0d expected %0d", bus.h, 4); end
        checks++;
        cancel = 1'b0;
        cycles(2);
        tick_sec(); tick_sec(); cycles(1);
        if ({flags, bus.h, disp} !== 19'd0) begin
            errors++; $display("FAIL refund_idle: got flags=%b h=%0d disp=%h expected all zero", flags, bus.h, disp);
        end
        checks++;
    endtask

    task automatic test_change_a();
        sel = 1'b1;
        cycles(3);
        coin_in(CC); coin_out();
        coin_in(CC); coin_out();
        coin_in(CC);
        if (disp !== 8'h15) begin errors++; $display("FAIL change_a_credit15: got %h expected %h", disp, 8'h15); end
        checks++;
        coin_out();
        if (flags !== 4'b1001) begin errors++; $display("FAIL change_a_flags: got %b expected %b", flags, 4'b1001); end
        checks++;
        if (bus.h !== 7'd3) begin errors++; $display("FAIL change_a_h: got %0d expected %0d", bus.h, 3); end
        checks++;
        tick_sec(); tick_sec(); cycles(1);
    endtask

    task automatic test_over_limit();
        reset_n = 1'b0;
        reset2_n = 1'b1;
        sel = 1'b0;
        cycles(3);
        coin_in(CC); coin_out();
        coin_in(CC); coin_out();
        coin_in(CC); coin_out();
        coin_in(CD); coin_out();
        coin_in(CU); coin_out();
        if (disp2 !== 8'h18) begin errors++; $display("FAIL limit_credit18: got %h expected %h", disp2, 8'h18); end
        checks++;
        coin_in(CC);
        if (bus2.coin_rej !== 1'b1) begin errors++; $display("FAIL limit_rej: got %b expected %b", bus2.coin_rej, 1'b1); end
        checks++;
        if (disp2 !== 8'h18) begin errors++; $display("FAIL limit_hold18: got %h expected %h", disp2, 8'h18); end
        checks++;
        coin_out();
        coin_in(CD);
        if (disp2 !== 8'h20) begin errors++; $display("FAIL limit_exact20: got %h expected %h", disp2, 8'h20); end
        checks++;
        coin_out();
        if (flags2 !== 4'b0101 || bus2.h !== 7'd0) begin
            errors++; $display("FAIL limit_vend: got flags=%b h=%0d expected flags=0101 h=0", flags2, bus2.h);
        end
        checks++;
        reset2_n = 1'b0;
        reset_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_simul_coins();
        sel = 1'b0;
        cycles(3);
        coin_in(CU | CC);
        if (disp !== 8'h01) begin errors++; $display("FAIL simul_credit: got %h expected %h", disp, 8'h01); end
        checks++;
        if (bus.coin_rej !== 1'b1) begin errors++; $display("FAIL simul_rej: got %b expected %b", bus.coin_rej, 1'b1); end
        checks++;
        coin_out();
        coin_u = 1'b1;
        cycles(50);
        if (disp !== 8'h02) begin errors++; $display("FAIL held_coin_once: got %h expected %h", disp, 8'h02); end
        checks++;
        coin_out();
        if (disp !== 8'h02) begin errors++; $display("FAIL held_coin_release: got %h expected %h", disp, 8'h02); end
        checks++;
        cancel = 1'b1; cycles(3); cancel = 1'b0;
        if (bus.h !== 7'd2) begin errors++; $display("FAIL simul_refund_h: got %0d expected %0d", bus.h, 2); end
        checks++;
        cycles(2);
        tick_sec(); tick_sec(); cycles(1);
    endtask

    task automatic test_sel_switch_reset();
        sel = 1'b1;
        cycles(3);
        coin_in(CC); coin_out();
        coin_in(CC); coin_out();
        if (flags !== 4'b0000) begin errors++; $display("FAIL switch_hold_a: got %b expected %b", flags, 4'b0000); end
        checks++;
        sel = 1'b0;
        cycles(2);
        if (flags !== 4'b0000) begin errors++; $display("FAIL switch_sync_delay: got %b expected %b", flags, 4'b0000); end
        checks++;
        cycles(1);
        if (flags !== 4'b0101 || bus.h !== 7'd1) begin
            errors++; $display("FAIL switch_vend_b: got flags=%b h=%0d expected flags=0101 h=1", flags, bus.h);
        end
        checks++;
        tick_sec();
        #2 reset_n = 1'b0;
        #1;
        if ({flags, bus.h, disp, bus.coin_rej} !== 20'd0) begin
            errors++; $display("FAIL async_reset: got flags=%b h=%0d disp=%h rej=%b expected all zero", flags, bus.h, disp, bus.coin_rej);
        end
        checks++;
        cycles(2);
        reset_n = 1'b1;
        tick_sec(); tick_sec(); cycles(3);
        if ({flags, disp} !== 12'd0) begin errors++; $display("FAIL post_reset_idle: got flags=%b disp=%h expected zero", flags, disp); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_vend_b();
        test_vend_a();
        test_refund();
        test_change_a();
        test_over_limit();
        test_simul_coins();
        test_sel_switch_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
